aw_burst_scheduler: RTL and testbench

//  Write-address sequencer of the DMA write path. On start, splits a write of btt bytes at

---
 rtl/aw_burst_if.sv | 28 ++
 rtl/aw_burst_scheduler.sv | 92 +++++++++
 tb/tb_aw_burst_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/aw_burst_if.sv
// aw_burst_if: start/status, B-confirm and AXI4 AW channel bundle for the write-address scheduler
interface aw_burst_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int BTT_WIDTH = 23
);
  logic start;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BTT_WIDTH-1:0] btt;
  logic busy;
  logic new_transaction;
  logic last_transaction;
  logic [8:0] burst_beats;
  logic transaction_confirmed;
  logic awvalid;
  logic awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  modport master (
    input start, addr, btt, transaction_confirmed, awready,
    output busy, new_transaction, last_transaction, burst_beats, awvalid, awaddr, awlen, awsize, awburst
  );
  modport slave (
    output start, addr, btt, transaction_confirmed, awready,
    input busy, new_transaction, last_transaction, burst_beats, awvalid, awaddr, awlen, awsize, awburst
  );
endinterface

// File: rtl/aw_burst_scheduler.sv
// aw_burst_scheduler: splits a write into 4 KiB-safe INCR bursts on AW, capping bursts awaiting B
module aw_burst_scheduler #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BTT_WIDTH = 23,
  parameter int MAX_BURST_LEN = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic clk,
  input logic rst,
  aw_burst_if.master bus
);
  localparam int LOW = $clog2(AXI_DATA_WIDTH / 8);
  localparam int BLW = BTT_WIDTH - LOW;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  state_t state;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [BLW-1:0] beats_left;
  logic [8:0] nb;
  logic [OW-1:0] outstanding;
  logic [12:0] b4k;
  logic [12:0] cap;
  logic [8:0] nb_c;
  logic hs;
  logic dec;
  always_comb begin
    b4k = (13'h1000 - {1'b0, cur_addr[11:0]}) >> LOW;
    cap = (13'(MAX_BURST_LEN) < b4k) ? 13'(MAX_BURST_LEN) : b4k;
    nb_c = ({13'b0, beats_left} < {{BLW{1'b0}}, cap}) ? 9'(beats_left) : 9'(cap);
    hs = bus.awvalid && bus.awready;
    dec = bus.transaction_confirmed && outstanding != '0;
  end
  assign bus.awsize = 3'(LOW);
  assign bus.awburst = 2'b01;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      beats_left <= '0;
      nb <= '0;
      outstanding <= '0;
      bus.busy <= 1'b0;
      bus.new_transaction <= 1'b0;
      bus.last_transaction <= 1'b0;
      bus.burst_beats <= '0;
      bus.awvalid <= 1'b0;
      bus.awaddr <= '0;
      bus.awlen <= '0;
    end else begin
      bus.new_transaction <= 1'b0;
      bus.last_transaction <= 1'b0;
      // a B response landing with an AW handshake leaves the count unchanged
      if (hs && !dec) outstanding <= outstanding + 1'b1;
      else if (dec && !hs) outstanding <= outstanding - 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          cur_addr <= (bus.addr >> LOW) << LOW;
          beats_left <= BLW'(bus.btt >> LOW);
          if ((bus.btt >> LOW) != '0) begin
            state <= CALC;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          bus.awaddr <= cur_addr;
          bus.awlen <= 8'(nb_c - 9'd1);
          nb <= nb_c;
          if (outstanding < OW'(MAX_OUTSTANDING)) begin
            state <= ISSUE;
            bus.awvalid <= 1'b1;
          end
        end
        ISSUE: if (bus.awready) begin
          bus.awvalid <= 1'b0;
          bus.new_transaction <= 1'b1;
          bus.burst_beats <= nb;
          cur_addr <= cur_addr + (AXI_ADDR_WIDTH'(nb) << LOW);
          beats_left <= beats_left - BLW'(nb);
          if (beats_left == BLW'(nb)) begin
            bus.last_transaction <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end else begin
            state <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aw_burst_scheduler.sv
// tb_aw_burst_scheduler: directed and random write jobs checked against a burst-list reference model
module tb_aw_burst_scheduler;
  localparam int MAXO = 2;
  typedef struct {
    logic [63:0] a;
    int nb;
    bit last;
  } burst_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int os_m = 0;
  int h0;
  logic [63:0] ra;
  logic [7:0] rl;
  burst_t q[$];
  aw_burst_if #(.ADDR_WIDTH(64), .BTT_WIDTH(23)) bus ();
  aw_burst_scheduler #(
    .AXI_DATA_WIDTH(64),
    .AXI_ADDR_WIDTH(64),
    .BTT_WIDTH(23),
    .MAX_BURST_LEN(16),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic plan(input logic [63:0] a0, input logic [22:0] b);
    logic [63:0] a;
    int beats, b4, nb;
    a = a0 & ~64'h7;
    beats = int'(b >> 3);
    while (beats > 0) begin
      b4 = (4096 - int'(a[11:0])) / 8;
      nb = beats;
      if (nb > 16) nb = 16;
      if (nb > b4) nb = b4;
      q.push_back('{a, nb, beats == nb});
      a += 64'(nb * 8);
      beats -= nb;
    end
  endtask
  task automatic step(input bit rdy, input bit conf, input bit st);
    bit hsb, cf;
    @(negedge clk);
    bus.start = st;
    bus.awready = rdy;
    bus.transaction_confirmed = conf && os_m > 0;
    if (bus.new_transaction) begin
      if (q.size() == 0) chk("spurious_new", 1, 0);
      else begin
        chk("burst_beats", 64'(bus.burst_beats), 64'(q[0].nb));
        chk("last", 64'(bus.last_transaction), 64'(q[0].last));
        if (q[0].last) chk("busy_fall", 64'(bus.busy), 0);
        void'(q.pop_front());
      end
    end else chk("last_alone", 64'(bus.last_transaction), 0);
    hsb = bus.awvalid && rdy;
    cf = bus.transaction_confirmed;
    if (hsb) begin
      hs_cnt++;
      chk("os_cap", 64'(os_m < MAXO), 1);
      if (q.size() == 0) chk("spurious_aw", 1, 0);
      else begin
        chk("awaddr", bus.awaddr, q[0].a);
        chk("awlen", 64'(bus.awlen), 64'(q[0].nb - 1));
      end
    end
    if (hsb && !cf) os_m++;
    else if (cf && !hsb) os_m--;
  endtask
  task automatic wait_done(input bit rmode, input bit cmode);
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && !bus.busy && !bus.awvalid) return;
      step(rmode ? ($urandom % 4 != 0) : 1'b1, cmode ? 1'($urandom % 2) : 1'b0, 1'b0);
    end
    chk("timeout", 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && os_m > 0; i++) step(1, 1, 0);
  endtask
  task automatic begin_job(input logic [63:0] a, input logic [22:0] b);
    bus.addr = a;
    bus.btt = b;
    plan(a, b);
    step(1, 0, 1);
    step(1, 0, 0);
    chk("busy_start", 64'(bus.busy), 64'((b >> 3) != 0));
  endtask
  task automatic run_job(input logic [63:0] a, input logic [22:0] b, input bit rmode);
    begin_job(a, b);
    wait_done(rmode, 1);
  endtask
  initial begin
    bus.start = 0;
    bus.addr = '0;
    bus.btt = '0;
    bus.awready = 0;
    bus.transaction_confirmed = 0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(bus.awvalid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_new", 64'(bus.new_transaction), 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_awlen", 64'(bus.awlen), 0);
    chk("awsize", 64'(bus.awsize), 3);
    chk("awburst", 64'(bus.awburst), 1);
    rst = 0;
    run_job(64'h1000, 23'd256, 0);
    run_job(64'h0FC0, 23'd128, 0);
    drain();
    h0 = hs_cnt;
    begin_job(64'h0, 23'd512);
    repeat (30) step(1, 0, 0);
    chk("stall_cnt", 64'(hs_cnt - h0), 2);
    chk("stall_valid", 64'(bus.awvalid), 0);
    step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    chk("resume_cnt", 64'(hs_cnt - h0), 3);
    wait_done(0, 1);
    drain();
    bus.addr = 64'h2000;
    bus.btt = 23'd256;
    plan(64'h2000, 23'd256);
    step(1, 0, 1);
    for (int i = 0; i < 10 && !bus.awvalid; i++) step(0, 0, 0);
    ra = bus.awaddr;
    rl = bus.awlen;
    repeat (5) begin
      step(0, 0, 0);
      chk("hold_valid", 64'(bus.awvalid), 1);
      chk("hold_addr", bus.awaddr, ra);
      chk("hold_len", 64'(bus.awlen), 64'(rl));
      chk("hold_new", 64'(bus.new_transaction), 0);
    end
    wait_done(0, 1);
    run_job(64'h4008, 23'd8, 0);
    run_job(64'h5000, 23'd4, 0);
    repeat (3) begin
      step(1, 0, 0);
      chk("tiny_awvalid", 64'(bus.awvalid), 0);
      chk("tiny_busy", 64'(bus.busy), 0);
    end
    drain();
    h0 = hs_cnt;
    begin_job(64'h0, 23'd256);
    for (int i = 0; i < 20; i++) begin
      step(hs_cnt == h0, 0, 0);
      if (hs_cnt - h0 == 1 && bus.awvalid && q.size() == 1) break;
    end
    chk("pre_rst_valid", 64'(bus.awvalid), 1);
    @(negedge clk);
    rst = 1;
    bus.awready = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_awvalid", 64'(bus.awvalid), 0);
    chk("rst_mid_busy", 64'(bus.busy), 0);
    q.delete();
    os_m = 0;
    h0 = hs_cnt;
    begin_job(64'h3000, 23'd512);
    repeat (30) step(1, 0, 0);
    chk("post_rst_cnt", 64'(hs_cnt - h0), 2);
    wait_done(0, 1);
    for (int j = 0; j < 20; j++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if (j % 3 == 1) a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      if (j % 3 == 2) a = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
      run_job(a, 23'($urandom_range(0, 3000)), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
